// File: rtl/tp_pkg.sv
// Shared types and colour constants for the HDMI test-pattern path.
// Colours are packed {B,G,R}, the same layout the pattern generator consumes.
package tp_pkg;

  typedef enum logic [2:0] {
    TP_COLOR_BAR = 3'd0,
    TP_NET_GRID  = 3'd1,
    TP_GRAY      = 3'd2,
    TP_SINGLE    = 3'd3
  } tp_mode_e;

  localparam logic [23:0] RGB_RED   = 24'h0000ff;
  localparam logic [23:0] RGB_GREEN = 24'h00ff00;
  localparam logic [23:0] RGB_BLUE  = 24'hff0000;
  localparam logic [23:0] RGB_WHITE = 24'hffffff;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  function automatic logic [23:0] solid_color(input logic [1:0] idx);
    case (idx)
      2'd0:    return RGB_RED;
      2'd1:    return RGB_GREEN;
      2'd2:    return RGB_BLUE;
      default: return RGB_WHITE;
    endcase
  endfunction

  function automatic tp_mode_e next_mode(input tp_mode_e m);
    case (m)
      TP_COLOR_BAR: return TP_NET_GRID;
      TP_NET_GRID:  return TP_GRAY;
      TP_GRAY:      return TP_SINGLE;
      default:      return TP_COLOR_BAR;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 742500
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Counter only runs while the synchronised sample disagrees with the accepted
  // level, so any bounce back to the old level restarts the window.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/test_pattern_sequencer.sv
// Run-time controller for the test-pattern generator: steps the pattern mode at
// start of frame on dwell expiry or a debounced button press, and cycles solid colours.
module test_pattern_sequencer
  import tp_pkg::*;
#(
  parameter int BIT_WIDTH          = 12,
  parameter int BIT_HEIGHT         = 11,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int SOLID_FRAMES       = 30,
  parameter int DEBOUNCE_CYCLES    = 742500
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic                  btn_next,
  input  logic                  auto_en,
  output logic [2:0]            mode,
  output logic [7:0]            color_r,
  output logic [7:0]            color_g,
  output logic [7:0]            color_b,
  output logic                  frame_tick
);

  localparam int DW = $clog2(FRAMES_PER_PATTERN + 1);
  localparam int SW = $clog2(SOLID_FRAMES + 1);

  tp_mode_e      state, state_nxt;
  logic [DW-1:0] dwell;
  logic [SW-1:0] solid;
  logic [1:0]    cidx, cidx_nxt;
  logic          pending, press, sof, expire, advance;
  logic [23:0]   bgr_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .btn       (btn_next),
    .press     (press)
  );

  assign sof     = (cx == '0) && (cy == '0);
  assign expire  = auto_en && (dwell == DW'(FRAMES_PER_PATTERN - 1));
  // A press landing on the SOF cycle itself still counts for this frame.
  assign advance = sof && (pending || press || expire);

  always_comb begin
    state_nxt = state;
    cidx_nxt  = cidx;
    if (advance) begin
      state_nxt = next_mode(state);
      cidx_nxt  = 2'd0;
    end else if (sof && state == TP_SINGLE && solid == SW'(SOLID_FRAMES - 1)) begin
      cidx_nxt  = cidx + 2'd1;
    end
    bgr_nxt = (state_nxt == TP_SINGLE) ? solid_color(cidx_nxt) : RGB_BLACK;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state      <= TP_COLOR_BAR;
      dwell      <= '0;
      solid      <= '0;
      cidx       <= 2'd0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      color_r    <= 8'd0;
      color_g    <= 8'd0;
      color_b    <= 8'd0;
    end else begin
      frame_tick <= sof;
      if (sof)        pending <= 1'b0;
      else if (press) pending <= 1'b1;

      if (!auto_en || advance) dwell <= '0;
      else if (sof)            dwell <= dwell + 1'b1;

      if (advance || state != TP_SINGLE) solid <= '0;
      else if (sof) solid <= (solid == SW'(SOLID_FRAMES - 1)) ? '0 : solid + 1'b1;

      state <= state_nxt;
      cidx  <= cidx_nxt;
      {color_b, color_g, color_r} <= bgr_nxt;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Directed bench for test_pattern_sequencer on a tiny 8x4 frame.
module tb_test_pattern_sequencer;

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b1;
  logic [11:0] cx        = '0;
  logic [10:0] cy        = '0;
  logic        btn_next  = 1'b0;
  logic        auto_en   = 1'b0;
  logic [2:0]  mode;
  logic [7:0]  color_r, color_g, color_b;
  logic        frame_tick;

  int pos    = 0;
  int passes = 0;
  int total  = 0;

  always #5 clk_pixel = ~clk_pixel;

  test_pattern_sequencer #(
    .BIT_WIDTH(12), .BIT_HEIGHT(11), .FRAMES_PER_PATTERN(3),
    .SOLID_FRAMES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .cx        (cx),
    .cy        (cy),
    .btn_next  (btn_next),
    .auto_en   (auto_en),
    .mode      (mode),
    .color_r   (color_r),
    .color_g   (color_g),
    .color_b   (color_b),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs are read just after the falling edge; inputs change at the same point.
  task automatic cyc();
    @(negedge clk_pixel);
    pos = (pos + 1) % 32;
    cx  = 12'(pos % 8);
    cy  = 11'(pos / 8);
  endtask

  task automatic goto_sof(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      seen = frame_tick;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic press(input int n);
    btn_next = 1'b1;
    repeat (n) cyc();
    btn_next = 1'b0;
  endtask

  function automatic logic [31:0] rgb();
    return {8'd0, color_r, color_g, color_b};
  endfunction

  initial begin
    int exp1 [13] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
    logic [31:0] exp4 [8] = '{32'hff0000, 32'h00ff00, 32'h00ff00, 32'h0000ff,
                              32'h0000ff, 32'hffffff, 32'hffffff, 32'hff0000};

    repeat (3) cyc();
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_rgb", rgb(), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);

    // 1: auto dwell of 3 frames
    auto_en = 1'b1;
    reset   = 1'b0;
    for (int k = 0; k < 13; k++) begin
      goto_sof("t1_sof");
      chk($sformatf("t1_mode_sof%0d", k + 1), 32'(mode), 32'(exp1[k]));
      cyc();
      chk("t1_tick_one_cycle", 32'(frame_tick), 32'd0);
    end

    // 2: long press steps once at next SOF; short glitch ignored
    auto_en = 1'b0;
    goto_sof("t2_sof");
    press(10);
    repeat (4) cyc();
    chk("t2_no_midframe_step", 32'(mode), 32'd0);
    goto_sof("t2_sof");
    chk("t2_step", 32'(mode), 32'd1);
    press(2);
    for (int k = 0; k < 3; k++) begin
      goto_sof("t2_sof");
      chk("t2_glitch_ignored", 32'(mode), 32'd1);
    end

    // 3: two presses in one frame collapse into one step
    press(6);
    repeat (6) cyc();
    press(6);
    repeat (6) cyc();
    chk("t3_no_midframe_step", 32'(mode), 32'd1);
    goto_sof("t3_sof");
    chk("t3_single_step", 32'(mode), 32'd2);
    goto_sof("t3_sof");
    chk("t3_pending_cleared", 32'(mode), 32'd2);

    // 4: solid colour cycling, then exit
    press(6);
    goto_sof("t4_sof");
    chk("t4_enter_single", 32'(mode), 32'd3);
    chk("t4_rgb_entry", rgb(), 32'hff0000);
    for (int k = 0; k < 8; k++) begin
      goto_sof("t4_sof");
      chk($sformatf("t4_rgb_sof%0d", k + 1), rgb(), exp4[k]);
    end
    chk("t4_still_single", 32'(mode), 32'd3);
    press(6);
    goto_sof("t4_sof");
    chk("t4_exit_mode", 32'(mode), 32'd0);
    chk("t4_exit_rgb", rgb(), 32'd0);

    // 5: press in the frame before expiry gives one step, dwell restarts
    auto_en = 1'b1;
    goto_sof("t5_sof");
    chk("t5_b", 32'(mode), 32'd0);
    goto_sof("t5_sof");
    chk("t5_c", 32'(mode), 32'd0);
    press(6);
    goto_sof("t5_sof");
    chk("t5_d_one_step", 32'(mode), 32'd1);
    goto_sof("t5_sof");
    chk("t5_e", 32'(mode), 32'd1);
    goto_sof("t5_sof");
    chk("t5_f", 32'(mode), 32'd1);
    goto_sof("t5_sof");
    chk("t5_g_dwell_step", 32'(mode), 32'd2);

    // 6: async reset mid-frame with a pending press
    press(6);
    repeat (4) cyc();
    chk("t6_pre_mode", 32'(mode), 32'd2);
    reset = 1'b1;
    #1;
    chk("t6_rst_mode", 32'(mode), 32'd0);
    chk("t6_rst_rgb", rgb(), 32'd0);
    chk("t6_rst_tick", 32'(frame_tick), 32'd0);
    repeat (3) cyc();
    reset = 1'b0;
    goto_sof("t6_sof");
    chk("t6_sof1", 32'(mode), 32'd0);
    goto_sof("t6_sof");
    chk("t6_sof2", 32'(mode), 32'd0);
    goto_sof("t6_sof");
    chk("t6_sof3", 32'(mode), 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
